vending_controller: RTL and testbench
=====================================

# vending_controller

Purchase controller for the vending machine. It sits directly downstream of the purchase stimulus stage and consumes that stage's three level-held command strobes (choose, insert money, give change) plus the product code and inserted amount. It validates the product, prices it, computes change, accumulates takings in the machine wallet, and emits single-cycle delivery or refund events to the output/display stage.

## Interface
- PRECO_1, default 50: price of product 1, in centavos.
- PRECO_2, default 75: price of product 2, in centavos.
- PRECO_3, default 100: price of product 3, in centavos.
- PRECO_4, default 125: price of product 4, in centavos.
- CARTEIRA_W, default 16: wallet width in bits.

- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- escolher  in  1  choose-product command; level-held for multiple cycles.
- inserir_dinheiro  in  1  insert-money command; level-held.
- dar_troco  in  1  give-change/complete command; level-held.
- produto_escolhido  in  8  product code; valid codes are 1..4.
- dinheiro_inserido  in  8  inserted amount in centavos (0..255).
- entregar  out  1  one-cycle pulse: product delivered.
- devolver  out  1  one-cycle pulse: purchase refused and money returned.
- erro  out  1  one-cycle pulse: invalid product code.
- produto_entregue  out  8  product code latched for this purchase.
- troco  out  8  change or refund amount; valid while entregar or devolver is high, 0 otherwise.
- carteira  out  CARTEIRA_W  accumulated takings; saturates at all-ones.
- estado  out  2  current state encoding.
- ocupado  out  1  high in any state other than OCIOSO.

## Operation
- States and encodings: OCIOSO=0, AGUARDA_DINHEIRO=1, AGUARDA_TROCO=2, FINALIZA=3.
- OCIOSO, with escolher=1:
  - Code 1..4: latch the code and its price; go to AGUARDA_DINHEIRO.
  - Any other code (including 0): pulse erro; stay in OCIOSO.
- AGUARDA_DINHEIRO, with inserir_dinheiro=1: latch dinheiro_inserido; go to AGUARDA_TROCO.
- AGUARDA_TROCO, with dar_troco=1: go to FINALIZA.
- FINALIZA, which lasts exactly one cycle and then returns to OCIOSO:
  - If inserted ≥ price: entregar=1, troco = inserted − price, carteira += price.
  - If inserted < price: devolver=1, troco = inserted, carteira unchanged.
- Inputs are levels. Each state reacts only to its own command; all other commands are ignored.
  - A command still held after its state is left has no further effect. Example: dar_troco still high in OCIOSO does nothing.
- Simultaneous commands: only the one relevant to the current state is honoured.
- produto_escolhido and dinheiro_inserido are sampled only at the edge where the state accepts them. Later changes are ignored.
- Arithmetic:
  - The change subtraction is 8-bit and never underflows, because of the ≥ compare.
  - The wallet add is CARTEIRA_W bits and saturates at 2^CARTEIRA_W − 1 instead of wrapping.
- produto_entregue holds the last accepted code until the next accepted code. It is cleared only by reset.

## Timing
- Reset values: estado=OCIOSO, entregar=0, devolver=0, erro=0, produto_entregue=0, troco=0, carteira=0, ocupado=0.
- Reset is asynchronous at any point, including mid-purchase. It immediately clears all state and the latched values, with no delivery or refund.
- All outputs are registered.
- Latency, with the commands asserted back to back:
  - escolher sampled at edge N: estado=1 after N.
  - inserir_dinheiro sampled at N+1: estado=2.
  - dar_troco sampled at N+2: estado=3, and entregar or devolver is high during the cycle after N+2.
  - estado=0 after N+3.
- erro is high for the single cycle following the sampling edge.
- entregar, devolver and erro are mutually exclusive.
- carteira updates on the same edge that raises entregar.

## Test plan
- Reset, select product 1, insert 150, dar_troco → one entregar pulse, troco=100, produto_entregue=1, carteira=50, then estado=0.
- Continue from the previous scenario: product 2, insert 100, dar_troco → entregar, troco=25, carteira=125.
- Product 3, insert 60, dar_troco → devolver pulse, troco=60, no entregar, carteira unchanged.
- escolher with code 0, then with code 7 → one erro pulse each, estado stays 0. Then code 4, insert 125 → entregar, troco=0.
- Assert reset_n low while in AGUARDA_TROCO → all outputs return to reset values immediately. A dar_troco held after reset is released has no effect.
- CARTEIRA_W=8: four purchases of product 4 with exact money (125 each) → carteira saturates at 255 and does not wrap. Hold each command for 10 cycles and confirm exactly one pulse per purchase.

Source files
------------

// File: rtl/vending_controller.sv
// -----------------------------------------------------------------------------
// vending_controller
//
// Purchase controller for the vending machine. It runs one purchase at a time:
// choose a product, insert money, then complete the purchase. It validates the
// product code, looks up the price, works out the change and adds the takings
// to the machine wallet. Delivery, refund and error events leave as
// single-cycle pulses.
//
// Parameters
//   PRECO_1..PRECO_4  price of products 1..4, in centavos (8-bit values)
//   CARTEIRA_W        wallet width in bits; the wallet saturates at all-ones
//
// Ports
//   clock              in   single clock, rising edge
//   reset_n            in   asynchronous active-low reset
//   escolher           in   choose-product command (level)
//   inserir_dinheiro   in   insert-money command (level)
//   dar_troco          in   give-change / complete command (level)
//   produto_escolhido  in   [7:0] product code, valid codes 1..4
//   dinheiro_inserido  in   [7:0] inserted amount in centavos
//   entregar           out  one-cycle pulse: product delivered
//   devolver           out  one-cycle pulse: purchase refused, money returned
//   erro               out  one-cycle pulse: invalid product code
//   produto_entregue   out  [7:0] product code of the last accepted choice
//   troco              out  [7:0] change/refund, valid with entregar/devolver
//   carteira           out  [CARTEIRA_W-1:0] accumulated takings
//   estado             out  [1:0] current state encoding
//   ocupado            out  high whenever a purchase is in progress
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module vending_controller #(
  parameter int unsigned PRECO_1    = 50,
  parameter int unsigned PRECO_2    = 75,
  parameter int unsigned PRECO_3    = 100,
  parameter int unsigned PRECO_4    = 125,
  parameter int unsigned CARTEIRA_W = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  escolher,
  input  logic                  inserir_dinheiro,
  input  logic                  dar_troco,
  input  logic [7:0]            produto_escolhido,
  input  logic [7:0]            dinheiro_inserido,
  output logic                  entregar,
  output logic                  devolver,
  output logic                  erro,
  output logic [7:0]            produto_entregue,
  output logic [7:0]            troco,
  output logic [CARTEIRA_W-1:0] carteira,
  output logic [1:0]            estado,
  output logic                  ocupado
);

  // Prices live in 8 bits so the change subtraction stays 8-bit.
  localparam logic [7:0] PRICE_1 = 8'(PRECO_1);
  localparam logic [7:0] PRICE_2 = 8'(PRECO_2);
  localparam logic [7:0] PRICE_3 = 8'(PRECO_3);
  localparam logic [7:0] PRICE_4 = 8'(PRECO_4);

  typedef enum logic [1:0] {
    OCIOSO           = 2'd0,
    AGUARDA_DINHEIRO = 2'd1,
    AGUARDA_TROCO    = 2'd2,
    FINALIZA         = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                estado_q,   estado_d;
  logic [7:0]            produto_q,  produto_d;   // latched product code
  logic [7:0]            preco_q,    preco_d;     // price of latched product
  logic [7:0]            dinheiro_q, dinheiro_d;  // latched inserted amount
  logic [CARTEIRA_W-1:0] carteira_q, carteira_d;
  logic [7:0]            troco_q,    troco_d;
  logic                  entregar_q, entregar_d;
  logic                  devolver_q, devolver_d;
  logic                  erro_q,     erro_d;
  logic                  ocupado_q,  ocupado_d;

  // Wallet sum carries one extra bit so an overflow can be seen and clamped.
  logic [CARTEIRA_W:0]   wallet_sum;
  logic                  code_valid;

  function automatic logic [7:0] price_of(input logic [7:0] code);
    logic [7:0] price;
    price = 8'd0;
    case (code)
      8'd1:    price = PRICE_1;
      8'd2:    price = PRICE_2;
      8'd3:    price = PRICE_3;
      8'd4:    price = PRICE_4;
      default: price = 8'd0;
    endcase
    return price;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement, so no
    // path through the block can leave one unassigned and infer a latch.
    estado_d   = estado_q;
    produto_d  = produto_q;
    preco_d    = preco_q;
    dinheiro_d = dinheiro_q;
    carteira_d = carteira_q;
    troco_d    = 8'd0;
    entregar_d = 1'b0;
    devolver_d = 1'b0;
    erro_d     = 1'b0;

    code_valid = (produto_escolhido >= 8'd1) && (produto_escolhido <= 8'd4);
    wallet_sum = {1'b0, carteira_q} + (CARTEIRA_W + 1)'(preco_q);

    case (estado_q)
      // Each state listens only to its own command; the others are ignored,
      // which also makes a command still held from the previous state harmless.
      OCIOSO: begin
        if (escolher) begin
          if (code_valid) begin
            produto_d = produto_escolhido;
            preco_d   = price_of(produto_escolhido);
            estado_d  = AGUARDA_DINHEIRO;
          end else begin
            erro_d = 1'b1;
          end
        end
      end

      AGUARDA_DINHEIRO: begin
        if (inserir_dinheiro) begin
          dinheiro_d = dinheiro_inserido;
          estado_d   = AGUARDA_TROCO;
        end
      end

      // The purchase is settled on the edge that enters FINALIZA, so the pulse,
      // the change and the wallet update all appear during FINALIZA.
      AGUARDA_TROCO: begin
        if (dar_troco) begin
          estado_d = FINALIZA;
          if (dinheiro_q >= preco_q) begin
            entregar_d = 1'b1;
            troco_d    = dinheiro_q - preco_q;
            carteira_d = wallet_sum[CARTEIRA_W] ? {CARTEIRA_W{1'b1}}
                                                : wallet_sum[CARTEIRA_W-1:0];
          end else begin
            devolver_d = 1'b1;
            troco_d    = dinheiro_q;
          end
        end
      end

      FINALIZA: begin
        estado_d = OCIOSO;
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase

    // Registered busy flag follows the state being entered.
    ocupado_d = (estado_d != OCIOSO);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every flop here, including the latched purchase data, is cleared by
  // reset so a purchase cut short by reset leaves nothing behind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      produto_q  <= 8'd0;
      preco_q    <= 8'd0;
      dinheiro_q <= 8'd0;
      carteira_q <= '0;
      troco_q    <= 8'd0;
      entregar_q <= 1'b0;
      devolver_q <= 1'b0;
      erro_q     <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, regardless of statement order.
      estado_q   <= estado_d;
      produto_q  <= produto_d;
      preco_q    <= preco_d;
      dinheiro_q <= dinheiro_d;
      carteira_q <= carteira_d;
      troco_q    <= troco_d;
      entregar_q <= entregar_d;
      devolver_q <= devolver_d;
      erro_q     <= erro_d;
      ocupado_q  <= ocupado_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign entregar         = entregar_q;
  assign devolver         = devolver_q;
  assign erro             = erro_q;
  assign produto_entregue = produto_q;
  assign troco            = troco_q;
  assign carteira         = carteira_q;
  assign estado           = estado_q;
  assign ocupado          = ocupado_q;

endmodule

// File: tb/tb_vending_controller.sv
// -----------------------------------------------------------------------------
// tb_vending_controller
//
// Self-checking bench for vending_controller. Two instances share the stimulus:
// one with the default 16-bit wallet and one with an 8-bit wallet, so wallet
// saturation can be reached quickly. A purchase-level reference model predicts
// every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_vending_controller;

  logic       clock;
  logic       reset_n;
  logic       escolher;
  logic       inserir_dinheiro;
  logic       dar_troco;
  logic [7:0] produto_escolhido;
  logic [7:0] dinheiro_inserido;

  logic        entregar_a, devolver_a, erro_a, ocupado_a;
  logic [7:0]  produto_entregue_a, troco_a;
  logic [15:0] carteira_a;
  logic [1:0]  estado_a;

  logic        entregar_b, devolver_b, erro_b, ocupado_b;
  logic [7:0]  produto_entregue_b, troco_b;
  logic [7:0]  carteira_b;
  logic [1:0]  estado_b;

  vending_controller dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .escolher          (escolher),
    .inserir_dinheiro  (inserir_dinheiro),
    .dar_troco         (dar_troco),
    .produto_escolhido (produto_escolhido),
    .dinheiro_inserido (dinheiro_inserido),
    .entregar          (entregar_a),
    .devolver          (devolver_a),
    .erro              (erro_a),
    .produto_entregue  (produto_entregue_a),
    .troco             (troco_a),
    .carteira          (carteira_a),
    .estado            (estado_a),
    .ocupado           (ocupado_a)
  );

  vending_controller #(.CARTEIRA_W(8)) dut8 (
    .clock             (clock),
    .reset_n           (reset_n),
    .escolher          (escolher),
    .inserir_dinheiro  (inserir_dinheiro),
    .dar_troco         (dar_troco),
    .produto_escolhido (produto_escolhido),
    .dinheiro_inserido (dinheiro_inserido),
    .entregar          (entregar_b),
    .devolver          (devolver_b),
    .erro              (erro_b),
    .produto_entregue  (produto_entregue_b),
    .troco             (troco_b),
    .carteira          (carteira_b),
    .estado            (estado_b),
    .ocupado           (ocupado_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: where the current purchase stands, plus what it has
  // latched and what the wallets hold.
  // step: 0 idle, 1 product chosen, 2 money in, 3 settling
  // ---------------------------------------------------------------------------
  int m_step;
  int m_code, m_price, m_money;
  int m_wallet16, m_wallet8;
  int m_ent, m_dev, m_err, m_troco;

  function automatic int price_table(input int code);
    int prices[4] = '{50, 75, 100, 125};
    return prices[code - 1];
  endfunction

  task automatic model_reset();
    m_step = 0; m_code = 0; m_price = 0; m_money = 0;
    m_wallet16 = 0; m_wallet8 = 0;
    m_ent = 0; m_dev = 0; m_err = 0; m_troco = 0;
  endtask

  task automatic model_edge();
    m_ent = 0; m_dev = 0; m_err = 0; m_troco = 0;
    if (m_step == 0) begin
      if (escolher) begin
        if (produto_escolhido >= 1 && produto_escolhido <= 4) begin
          m_code  = int'(produto_escolhido);
          m_price = price_table(m_code);
          m_step  = 1;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_step == 1) begin
      if (inserir_dinheiro) begin
        m_money = int'(dinheiro_inserido);
        m_step  = 2;
      end
    end else if (m_step == 2) begin
      if (dar_troco) begin
        m_step = 3;
        if (m_money >= m_price) begin
          m_ent      = 1;
          m_troco    = m_money - m_price;
          m_wallet16 = (m_wallet16 + m_price > 65535) ? 65535 : m_wallet16 + m_price;
          m_wallet8  = (m_wallet8 + m_price > 255) ? 255 : m_wallet8 + m_price;
        end else begin
          m_dev   = 1;
          m_troco = m_money;
        end
      end
    end else begin
      m_step = 0;
    end
  endtask

  // Pulse counters and last observed change, used by the directed scenarios.
  int ent_cnt, dev_cnt, err_cnt, ent8_cnt;
  int last_troco;

  task automatic compare_all(input string ctx);
    check({ctx, ".estado"},    32'(estado_a),           32'(m_step));
    check({ctx, ".ocupado"},   32'(ocupado_a),          32'(m_step != 0));
    check({ctx, ".entregar"},  32'(entregar_a),         32'(m_ent));
    check({ctx, ".devolver"},  32'(devolver_a),         32'(m_dev));
    check({ctx, ".erro"},      32'(erro_a),             32'(m_err));
    check({ctx, ".troco"},     32'(troco_a),            32'(m_troco));
    check({ctx, ".produto"},   32'(produto_entregue_a), 32'(m_code));
    check({ctx, ".carteira"},  32'(carteira_a),         32'(m_wallet16));
    check({ctx, ".estado8"},   32'(estado_b),           32'(m_step));
    check({ctx, ".entregar8"}, 32'(entregar_b),         32'(m_ent));
    check({ctx, ".devolver8"}, 32'(devolver_b),         32'(m_dev));
    check({ctx, ".troco8"},    32'(troco_b),            32'(m_troco));
    check({ctx, ".carteira8"}, 32'(carteira_b),         32'(m_wallet8));
    if (entregar_a) begin ent_cnt++; last_troco = int'(troco_a); end
    if (devolver_a) begin dev_cnt++; last_troco = int'(troco_a); end
    if (erro_a)     err_cnt++;
    if (entregar_b) ent8_cnt++;
  endtask

  // One clock: the model sees the same inputs the DUT samples, then outputs
  // are compared 1 time unit after the edge.
  task automatic tick(input string ctx);
    @(posedge clock);
    if (reset_n) model_edge();
    #1;
    compare_all(ctx);
  endtask

  task automatic clear_counts();
    ent_cnt = 0; dev_cnt = 0; err_cnt = 0; ent8_cnt = 0; last_troco = -1;
  endtask

  // Full purchase with each command held for 'hold' cycles.
  task automatic purchase(input int code, input int money, input int hold,
                          input string ctx);
    produto_escolhido = 8'(code);
    dinheiro_inserido = 8'(money);
    escolher = 1'b1;
    repeat (hold) tick({ctx, ".sel"});
    escolher = 1'b0;
    inserir_dinheiro = 1'b1;
    repeat (hold) tick({ctx, ".ins"});
    inserir_dinheiro = 1'b0;
    dar_troco = 1'b1;
    repeat (hold) tick({ctx, ".fin"});
    dar_troco = 1'b0;
    tick({ctx, ".idle"});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset_n           = 1'b0;
    escolher          = 1'b0;
    inserir_dinheiro  = 1'b0;
    dar_troco         = 1'b0;
    produto_escolhido = 8'd0;
    dinheiro_inserido = 8'd0;
    model_reset();
    clear_counts();

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    compare_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Product 1, insert 150
    clear_counts();
    purchase(1, 150, 1, "p1");
    check("p1.ent_pulses", 32'(ent_cnt), 32'd1);
    check("p1.troco_val", 32'(last_troco), 32'd100);
    check("p1.produto_val", 32'(produto_entregue_a), 32'd1);
    check("p1.carteira_val", 32'(carteira_a), 32'd50);
    check("p1.estado_val", 32'(estado_a), 32'd0);

    // Product 2, insert 100
    clear_counts();
    purchase(2, 100, 1, "p2");
    check("p2.ent_pulses", 32'(ent_cnt), 32'd1);
    check("p2.troco_val", 32'(last_troco), 32'd25);
    check("p2.carteira_val", 32'(carteira_a), 32'd125);

    // Product 3, insert 60: refused
    clear_counts();
    purchase(3, 60, 1, "p3");
    check("p3.dev_pulses", 32'(dev_cnt), 32'd1);
    check("p3.ent_pulses", 32'(ent_cnt), 32'd0);
    check("p3.troco_val", 32'(last_troco), 32'd60);
    check("p3.carteira_val", 32'(carteira_a), 32'd125);

    // Invalid codes 0 and 7, then product 4 with exact money
    clear_counts();
    produto_escolhido = 8'd0;
    escolher = 1'b1;
    tick("inv0");
    escolher = 1'b0;
    tick("inv0.gap");
    produto_escolhido = 8'd7;
    escolher = 1'b1;
    tick("inv7");
    escolher = 1'b0;
    tick("inv7.gap");
    check("inv.err_pulses", 32'(err_cnt), 32'd2);
    check("inv.estado_val", 32'(estado_a), 32'd0);
    purchase(4, 125, 1, "p4");
    check("p4.ent_pulses", 32'(ent_cnt), 32'd1);
    check("p4.troco_val", 32'(last_troco), 32'd0);

    // Asynchronous reset while waiting for dar_troco
    produto_escolhido = 8'd2;
    dinheiro_inserido = 8'd200;
    escolher = 1'b1;
    tick("rst.sel");
    escolher = 1'b0;
    inserir_dinheiro = 1'b1;
    tick("rst.ins");
    inserir_dinheiro = 1'b0;
    check("rst.pre_estado", 32'(estado_a), 32'd2);
    dar_troco = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst.async");
    @(negedge clock);
    reset_n = 1'b1;
    clear_counts();
    repeat (4) tick("rst.held");
    dar_troco = 1'b0;
    check("rst.no_ent", 32'(ent_cnt + dev_cnt), 32'd0);

    // Four product-4 purchases, commands held 10 cycles: 8-bit wallet saturates
    clear_counts();
    for (int k = 0; k < 4; k++) purchase(4, 125, 10, "sat");
    check("sat.ent8_pulses", 32'(ent8_cnt), 32'd4);
    check("sat.carteira8_val", 32'(carteira_b), 32'd255);
    check("sat.carteira16_val", 32'(carteira_a), 32'd500);

    // Randomized per-cycle commands, including overlapping and held strobes,
    // and codes/amounts that change while a purchase is in progress.
    for (int c = 0; c < 3000; c++) begin
      escolher          = ($urandom_range(0, 99) < 35);
      inserir_dinheiro  = ($urandom_range(0, 99) < 40);
      dar_troco         = ($urandom_range(0, 99) < 40);
      produto_escolhido = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                      : 8'($urandom_range(0, 5));
      dinheiro_inserido = 8'($urandom);
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
